// File: rtl/pset4_pkg.sv
// Shared definitions for the pset4 pipeline: supported opcodes and the
// fetch-stage state encoding.
package pset4_pkg;

   localparam logic [7:0] OP_ADD_EAX_IMM  = 8'h05;
   localparam logic [7:0] OP_ADD_RM       = 8'h01;
   localparam logic [7:0] OP_MOV_RM       = 8'h89;
   localparam logic [7:0] OP_MOV_IMM_BASE = 8'hB8;
   localparam logic [7:0] OP_JMP_REL8     = 8'hEB;
   localparam logic [7:0] OP_JMP_REL32    = 8'hE9;
   localparam logic [7:0] OP_HLT          = 8'hF4;

   typedef enum logic [2:0] {
      REQ,
      WAIT,
      WAIT_DRAIN,
      HOLD,
      HALTED
   } fetch_state_t;

endpackage

// File: rtl/adder32.sv
// Plain 32-bit wrapping adder shared by the pipeline stages.
module adder32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/ilen_predecode.sv
// Combinational instruction-length pre-decode from the first opcode byte.
module ilen_predecode
   import pset4_pkg::*;
(
   input  logic [7:0]  b0,
   output logic [31:0] length,
   output logic        illegal
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      length  = 32'd1;
      illegal = 1'b0;
      if (b0[7:3] == OP_MOV_IMM_BASE[7:3]) begin
         length = 32'd5;
      end else begin
         case (b0)
            OP_ADD_EAX_IMM: length = 32'd5;
            OP_ADD_RM:      length = 32'd2;
            OP_MOV_RM:      length = 32'd2;
            OP_JMP_REL8:    length = 32'd2;
            OP_JMP_REL32:   length = 32'd5;
            OP_HLT:         length = 32'd1;
            default:        illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Pipeline front end: owns the PC, issues one imem read at a time, pre-decodes
// length and hands packets to decode; honours execute's jump/halt redirects.
module fetch_stage
   import pset4_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          FETCH_BYTES = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       imem_req,
   output logic [31:0]                imem_addr,
   input  logic                       imem_rvalid,
   input  logic [FETCH_BYTES*8-1:0]   imem_rdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_instr_length,
   output logic [FETCH_BYTES*8-1:0]   out_bytes,
   output logic                       out_illegal,
   input  logic                       ex_valid,
   input  logic                       ex_is_jmp,
   input  logic [31:0]                ex_jmp_target,
   input  logic                       ex_is_halt,
   output logic                       halted
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  pc_seq;
   logic [31:0]  dec_len;
   logic         dec_illegal;
   logic         epoch;
   logic         req_epoch;
   logic         halt_hit;
   logic         redirect;

   assign halt_hit = ex_valid & ex_is_halt;
   assign redirect = ex_valid & ex_is_jmp & ~ex_is_halt;

   ilen_predecode u_predecode (
      .b0      (imem_rdata[7:0]),
      .length  (dec_len),
      .illegal (dec_illegal)
   );

   adder32 u_pc_add (
      .a   (pc),
      .b   (out_instr_length),
      .sum (pc_seq)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= REQ;
         pc               <= RESET_PC;
         epoch            <= 1'b0;
         req_epoch        <= 1'b0;
         imem_req         <= 1'b0;
         imem_addr        <= 32'h0;
         out_valid        <= 1'b0;
         out_pc           <= 32'h0;
         out_instr_length <= 32'h0;
         out_bytes        <= '0;
         out_illegal      <= 1'b0;
         halted           <= 1'b0;
      end else begin
         imem_req <= 1'b0;
         if (state != HALTED && halt_hit) begin
            state     <= HALTED;
            out_valid <= 1'b0;
            halted    <= 1'b1;
         end else if (state != HALTED && redirect) begin
            pc        <= ex_jmp_target;
            epoch     <= ~epoch;
            out_valid <= 1'b0;
            // A read still in flight must be drained before a new one may issue.
            if ((state == WAIT || state == WAIT_DRAIN) && !imem_rvalid)
               state <= WAIT_DRAIN;
            else
               state <= REQ;
         end else begin
            case (state)
               REQ: begin
                  imem_req  <= 1'b1;
                  imem_addr <= pc;
                  req_epoch <= epoch;
                  state     <= WAIT;
               end
               WAIT: begin
                  if (imem_rvalid) begin
                     if (req_epoch == epoch) begin
                        out_pc           <= pc;
                        out_instr_length <= dec_len;
                        out_bytes        <= imem_rdata;
                        out_illegal      <= dec_illegal;
                        out_valid        <= 1'b1;
                        state            <= HOLD;
                     end else begin
                        state <= REQ;
                     end
                  end
               end
               WAIT_DRAIN: begin
                  if (imem_rvalid)
                     state <= REQ;
               end
               HOLD: begin
                  if (out_ready) begin
                     pc        <= pc_seq;
                     out_valid <= 1'b0;
                     state     <= REQ;
                  end
               end
               HALTED: begin
                  out_valid <= 1'b0;
               end
               default: state <= REQ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// phase, all checked against an architectural PC/memory model.
module tb_fetch_stage;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [63:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr_length;
   logic [63:0] out_bytes;
   logic        out_illegal;
   logic        ex_valid;
   logic        ex_is_jmp;
   logic [31:0] ex_jmp_target;
   logic        ex_is_halt;
   logic        halted;

   fetch_stage #(.RESET_PC(RPC), .FETCH_BYTES(8)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_rvalid      (imem_rvalid),
      .imem_rdata       (imem_rdata),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_pc           (out_pc),
      .out_instr_length (out_instr_length),
      .out_bytes        (out_bytes),
      .out_illegal      (out_illegal),
      .ex_valid         (ex_valid),
      .ex_is_jmp        (ex_is_jmp),
      .ex_jmp_target    (ex_jmp_target),
      .ex_is_halt       (ex_is_halt),
      .halted           (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Byte-addressed program memory; untouched bytes are filled randomly on first read.
   logic [7:0]  mem [logic [31:0]];
   logic [31:0] model_pc;
   logic        halted_exp;
   int          pend;
   int          lat;
   logic [31:0] resp_addr;
   int          accepted;
   int          passed;
   int          total;

   function automatic logic [7:0] rd_byte(input logic [31:0] a);
      if (!mem.exists(a)) mem[a] = 8'($urandom);
      return mem[a];
   endfunction

   function automatic logic [63:0] rd_word(input logic [31:0] a);
      logic [63:0] w;
      for (int i = 0; i < 8; i++) w[i*8 +: 8] = rd_byte(a + 32'(i));
      return w;
   endfunction

   // Instruction-set length table.
   function automatic logic [31:0] spec_len(input logic [7:0] b);
      if (b >= 8'hB8 && b <= 8'hBF) return 32'd5;
      if (b == 8'h05 || b == 8'hE9) return 32'd5;
      if (b == 8'h01 || b == 8'h89 || b == 8'hEB) return 32'd2;
      return 32'd1;
   endfunction

   function automatic logic spec_illegal(input logic [7:0] b);
      return !((b >= 8'hB8 && b <= 8'hBF) || b == 8'h05 || b == 8'h01 ||
               b == 8'h89 || b == 8'hEB || b == 8'hE9 || b == 8'hF4);
   endfunction

   task automatic poke(input logic [31:0] a, input int n, input logic [63:0] w);
      for (int i = 0; i < n; i++) mem[a + 32'(i)] = w[i*8 +: 8];
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Memory responder: one response per request, lat cycles after the request is seen.
   task automatic imem_update();
      imem_rvalid = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = rd_word(resp_addr);
         end
      end
      if (imem_req && !halted_exp) begin
         check("one_outstanding", 64'(pend), 64'd0);
         pend      = lat;
         resp_addr = imem_addr;
      end
   endtask

   // One clock: drive at negedge, update the model at posedge, check at the next negedge.
   task automatic cycle(input logic rdy, input logic exv, input logic jmp,
                        input logic hlt, input logic [31:0] tgt);
      logic pre_valid;
      out_ready     = rdy;
      ex_valid      = exv;
      ex_is_jmp     = jmp;
      ex_is_halt    = hlt;
      ex_jmp_target = tgt;
      pre_valid     = out_valid;
      @(posedge clk);
      if (exv && hlt) begin
         halted_exp = 1'b1;
      end else if (!halted_exp && exv && jmp) begin
         model_pc = tgt;
      end else if (!halted_exp && pre_valid && rdy) begin
         accepted++;
         model_pc = model_pc + spec_len(rd_byte(model_pc));
      end
      @(negedge clk);
      out_ready  = 1'b0;
      ex_valid   = 1'b0;
      ex_is_jmp  = 1'b0;
      ex_is_halt = 1'b0;
      check("halted", 64'(halted), 64'(halted_exp));
      if (halted_exp) begin
         check("halt_no_req", 64'(imem_req), 64'd0);
         check("halt_no_valid", 64'(out_valid), 64'd0);
      end else begin
         check("no_prefetch", 64'(imem_req && out_valid), 64'd0);
         if (imem_req) check("imem_addr", 64'(imem_addr), 64'(model_pc));
         if (out_valid) begin
            check("out_pc", 64'(out_pc), 64'(model_pc));
            check("out_len", 64'(out_instr_length), 64'(spec_len(rd_byte(model_pc))));
            check("out_illegal", 64'(out_illegal), 64'(spec_illegal(rd_byte(model_pc))));
            check("out_bytes", out_bytes, rd_word(model_pc));
         end
      end
      imem_update();
   endtask

   task automatic idle(input logic rdy);
      cycle(rdy, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (out_valid) break;
         idle(1'b0);
      end
      check(tag, 64'(out_valid), 64'd1);
   endtask

   task automatic wait_req(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (imem_req) break;
         idle(1'b1);
      end
      check(tag, 64'(imem_req), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},    64'(imem_req), 64'd0);
      check({tag, "_valid"},  64'(out_valid), 64'd0);
      check({tag, "_pc"},     64'(out_pc), 64'd0);
      check({tag, "_len"},    64'(out_instr_length), 64'd0);
      check({tag, "_bytes"},  out_bytes, 64'd0);
      check({tag, "_ill"},    64'(out_illegal), 64'd0);
      check({tag, "_halted"}, 64'(halted), 64'd0);
   endtask

   initial begin
      logic [31:0] snap_pc;
      logic [31:0] snap_len;
      logic [63:0] snap_bytes;
      int          target;
      logic        rdy;
      logic        jmp;
      logic        exv;

      passed = 0; total = 0; accepted = 0;
      pend = 0; lat = 2; halted_exp = 1'b0; model_pc = RPC;
      rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
      ex_valid = 1'b0; ex_is_jmp = 1'b0; ex_is_halt = 1'b0; ex_jmp_target = '0;

      poke(32'h100, 5, 64'h44_33_22_11_05);
      poke(32'h105, 1, 64'h0F);
      poke(32'h106, 2, 64'hC0_01);
      poke(32'h108, 2, 64'hD8_89);
      poke(32'h10A, 5, 64'h12_34_56_78_BB);
      poke(32'h10F, 2, 64'h10_EB);
      poke(32'h111, 5, 64'h00_00_01_00_E9);
      poke(32'h116, 1, 64'hF4);
      poke(32'h117, 1, 64'hC3);
      poke(32'hFFFF_FFFE, 2, 64'hC0_01);

      // Reset state
      #2;
      check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Straight-line program with 2-cycle memory, decode always ready
      for (int i = 0; i < 200 && accepted < 9; i++) idle(1'b1);
      check("prog_accepted", 64'(accepted), 64'd9);

      // Backpressure: packet must hold still for 4 cycles with no new request
      wait_valid("bp_valid");
      snap_pc = out_pc; snap_len = out_instr_length; snap_bytes = out_bytes;
      for (int i = 0; i < 4; i++) begin
         idle(1'b0);
         check("bp_valid_held", 64'(out_valid), 64'd1);
         check("bp_pc_stable", 64'(out_pc), 64'(snap_pc));
         check("bp_len_stable", 64'(out_instr_length), 64'(snap_len));
         check("bp_bytes_stable", out_bytes, snap_bytes);
         check("bp_no_req", 64'(imem_req), 64'd0);
      end
      snap_pc = model_pc;
      idle(1'b1);
      wait_req("bp_next_req");
      check("bp_next_addr", 64'(imem_addr), 64'(snap_pc + spec_len(rd_byte(snap_pc))));

      // Redirect while a read is outstanding: stale response must be dropped
      lat = 3;
      wait_req("redir_req");
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h200);
      wait_valid("redir_valid");
      check("redir_first_pc", 64'(out_pc), 64'h200);
      check("redir_first_bytes", out_bytes, rd_word(32'h200));
      idle(1'b1);

      // PC wrap: 2-byte instruction at 0xFFFF_FFFE continues at 0
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE);
      wait_valid("wrap_valid");
      check("wrap_len", 64'(out_instr_length), 64'd2);
      idle(1'b1);
      wait_req("wrap_req");
      check("wrap_addr", 64'(imem_addr), 64'h0);

      // Randomized traffic: variable latency, backpressure, redirects
      for (int i = 0; i < 600; i++) begin
         lat = $urandom_range(1, 4);
         rdy = ($urandom_range(0, 3) != 0);
         jmp = ($urandom_range(0, 15) == 0);
         exv = jmp | ($urandom_range(0, 7) == 0);
         target = ($urandom_range(0, 1) == 1) ? int'($urandom) : 32'h100 + $urandom_range(0, 64);
         cycle(rdy, exv, jmp, 1'b0, 32'(target));
      end

      // Reset while waiting on memory; a late response in REQ must be ignored
      lat = 2;
      wait_req("rst_req");
      idle(1'b0);
      rst_n = 1'b0;
      pend = 0;
      imem_rvalid = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      model_pc = RPC;
      imem_rvalid = 1'b1;
      imem_rdata = 64'hDEAD_BEEF_0F0F_0F0F;
      idle(1'b0);
      check("rst_fresh_req", 64'(imem_req), 64'd1);
      wait_valid("rst_valid");
      check("rst_first_pc", 64'(out_pc), 64'(RPC));
      check("rst_first_bytes", out_bytes, rd_word(RPC));

      // Jump and halt together: halt wins, fetch stops for good
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h300);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h400);
         else idle(1'b1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
